// File: rtl/redirect_ctrl.sv
// redirect_ctrl: PC-redirect scheduler for the RV32 core.
// Picks one redirect per cycle from trap/jump/branch (trap > jump > branch),
// drives the fetch PC-load port, holds a redirect while fetch is stalled, and
// squashes wrong-path instructions for FLUSH_CYCLES advancing cycles afterwards.
// Ports:
//   i_clk, i_rst                  clock, async active-low reset
//   i_stall                       fetch stalled (no consume, no flush advance)
//   i_{trap,jump,branch}_req/target   redirect requests and targets
//   o_pc_update_control/val       PC load strobe and new PC (same-cycle)
//   o_ignore_curr_inst            squash instruction in decode/execute
//   o_redirect_src                0 none, 1 branch, 2 jump, 3 trap
//   o_misaligned                  strobed target has bit[1] set
//   o_busy                        controller not idle
module redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_trap_req,
  input  logic [XLEN-1:0] i_trap_target,
  input  logic            i_jump_req,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_branch_req,
  input  logic [XLEN-1:0] i_branch_target,
  output logic            o_pc_update_control,
  output logic [XLEN-1:0] o_pc_update_val,
  output logic            o_ignore_curr_inst,
  output logic [1:0]      o_redirect_src,
  output logic            o_misaligned,
  output logic            o_busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_TRAP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic [1:0]        src_q, src_d;

  logic              any_req;
  logic [1:0]        win_src;
  logic [XLEN-1:0]   win_tgt;
  logic [XLEN-1:0]   trap_tgt;

  logic              strobe;
  logic [XLEN-1:0]   val;
  logic [1:0]        src_out;
  logic              ignore;

  // Fixed-priority winner; bit[0] of every target is cleared (JALR rule)
  always_comb begin
    any_req  = i_trap_req | i_jump_req | i_branch_req;
    trap_tgt = {i_trap_target[XLEN-1:1], 1'b0};
    win_src  = SRC_NONE;
    win_tgt  = '0;
    if (i_trap_req) begin
      win_src = SRC_TRAP;
      win_tgt = trap_tgt;
    end else if (i_jump_req) begin
      win_src = SRC_JUMP;
      win_tgt = {i_jump_target[XLEN-1:1], 1'b0};
    end else if (i_branch_req) begin
      win_src = SRC_BRANCH;
      win_tgt = {i_branch_target[XLEN-1:1], 1'b0};
    end
  end

  // State, flush counter and pending redirect registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      src_q   <= src_d;
    end
  end

  // Next-state and same-cycle redirect outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    src_d   = src_q;
    strobe  = 1'b0;
    val     = '0;
    src_out = SRC_NONE;
    ignore  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          if (!i_stall) begin
            strobe  = 1'b1;
            val     = win_tgt;
            src_out = win_src;
            state_d = ST_FLUSH;
            cnt_d   = CNT_LOAD;
          end else begin
            tgt_d   = win_tgt;
            src_d   = win_src;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        src_out = src_q;
        // Only a trap may replace the held redirect
        if (i_trap_req) begin
          tgt_d = trap_tgt;
          src_d = SRC_TRAP;
        end
        if (!i_stall) begin
          strobe  = 1'b1;
          val     = i_trap_req ? trap_tgt : tgt_q;
          src_out = i_trap_req ? SRC_TRAP : src_q;
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        ignore = 1'b1;
        // Jump/branch here come from squashed instructions and are dropped
        if (i_trap_req) begin
          if (!i_stall) begin
            strobe  = 1'b1;
            val     = trap_tgt;
            src_out = SRC_TRAP;
            cnt_d   = CNT_LOAD;
          end else begin
            tgt_d   = trap_tgt;
            src_d   = SRC_TRAP;
            state_d = ST_PEND;
          end
        end else if (!i_stall) begin
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs forced low while reset is held, even with live requests
  always_comb begin
    o_pc_update_control = i_rst & strobe;
    o_pc_update_val     = i_rst ? val : '0;
    o_redirect_src      = i_rst ? src_out : SRC_NONE;
    o_ignore_curr_inst  = i_rst & ignore;
    o_misaligned        = i_rst & strobe & val[1];
    o_busy              = i_rst & (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: two instances (FLUSH_CYCLES=1 and 3) with
// gated inputs; expected strobes are queued by the stimulus and checked by
// per-instance monitors, status outputs are checked inline.
module tb_redirect_ctrl;

  typedef struct packed {
    logic [31:0] val;
    logic [1:0]  src;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en1, en3;
  logic        stall, treq, jreq, breq;
  logic [31:0] tt, jt, bt;

  logic        s1, ign1, mis1, busy1;
  logic [31:0] v1;
  logic [1:0]  src1;
  logic        s3, ign3, mis3, busy3;
  logic [31:0] v3;
  logic [1:0]  src3;

  exp_t q1[$];
  exp_t q3[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_stall(stall & en1),
    .i_trap_req(treq & en1), .i_trap_target(tt),
    .i_jump_req(jreq & en1), .i_jump_target(jt),
    .i_branch_req(breq & en1), .i_branch_target(bt),
    .o_pc_update_control(s1), .o_pc_update_val(v1),
    .o_ignore_curr_inst(ign1), .o_redirect_src(src1),
    .o_misaligned(mis1), .o_busy(busy1)
  );

  redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst(rst_n), .i_stall(stall & en3),
    .i_trap_req(treq & en3), .i_trap_target(tt),
    .i_jump_req(jreq & en3), .i_jump_target(jt),
    .i_branch_req(breq & en3), .i_branch_target(bt),
    .o_pc_update_control(s3), .o_pc_update_val(v3),
    .o_ignore_curr_inst(ign3), .o_redirect_src(src3),
    .o_misaligned(mis3), .o_busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clr();
    stall = 1'b0; treq = 1'b0; jreq = 1'b0; breq = 1'b0;
    tt = '0; jt = '0; bt = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] v, input logic [1:0] s, input logic m);
    exp_t e;
    e.val = v; e.src = s; e.mis = m;
    return e;
  endfunction

  // Strobe monitors: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && s1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL strobe1_unexpected actual val=%h src=%0d required none", v1, src1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (v1 !== e.val || src1 !== e.src || mis1 !== e.mis) begin
          n_fail++;
          $display("FAIL strobe1 actual val=%h src=%0d mis=%b required val=%h src=%0d mis=%b",
                   v1, src1, mis1, e.val, e.src, e.mis);
        end
      end
    end
    if (rst_n && s3) begin
      n_tests++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL strobe3_unexpected actual val=%h src=%0d required none", v3, src3);
      end else begin
        exp_t e;
        e = q3.pop_front();
        if (v3 !== e.val || src3 !== e.src || mis3 !== e.mis) begin
          n_fail++;
          $display("FAIL strobe3 actual val=%h src=%0d mis=%b required val=%h src=%0d mis=%b",
                   v3, src3, mis3, e.val, e.src, e.mis);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en1 = 1'b1; en3 = 1'b0;
    clr();
    // Reset with a live request: everything must stay low
    jreq = 1'b1; jt = 32'h0000_1003;
    @(negedge clk);
    chk("rst_strobe", 32'(s1), 0);
    chk("rst_val", v1, 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_src", 32'(src1), 0);
    clr();
    nxt();
    rst_n = 1'b1;

    // Jump in IDLE, no stall
    jreq = 1'b1; jt = 32'h0000_1003;
    q1.push_back(mk(32'h0000_1002, 2'd2, 1'b1));
    @(negedge clk);
    chk("t1_busy0", 32'(busy1), 0);
    nxt(); clr();
    @(negedge clk);
    chk("t1_ignore", 32'(ign1), 1);
    chk("t1_busy", 32'(busy1), 1);
    chk("t1_val_quiet", v1, 0);
    nxt();
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy1), 0);
    chk("t1_idle_ign", 32'(ign1), 0);

    // Simultaneous requests: trap wins; jump/branch held into FLUSH are dropped
    nxt();
    treq = 1'b1; tt = 32'h0000_0100;
    jreq = 1'b1; jt = 32'h0000_0200;
    breq = 1'b1; bt = 32'h0000_0300;
    q1.push_back(mk(32'h0000_0100, 2'd3, 1'b0));
    @(negedge clk);
    nxt();
    treq = 1'b0;
    @(negedge clk);
    chk("t2_flush_ign", 32'(ign1), 1);
    nxt(); clr();
    @(negedge clk);
    chk("t2_idle", 32'(busy1), 0);

    // Stall deferral of a branch
    nxt();
    breq = 1'b1; bt = 32'h0000_0400; stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      nxt();
      @(negedge clk);
      chk("t3_pend_src", 32'(src1), 1);
      chk("t3_pend_busy", 32'(busy1), 1);
    end
    nxt(); clr();
    q1.push_back(mk(32'h0000_0400, 2'd1, 1'b0));
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("t3_flush_ign", 32'(ign1), 1);
    nxt();
    @(negedge clk);
    chk("t3_idle", 32'(busy1), 0);

    // Trap overrides a pending branch while stalled
    nxt();
    breq = 1'b1; bt = 32'h0000_0500; stall = 1'b1;
    @(negedge clk);
    nxt(); breq = 1'b0; treq = 1'b1; tt = 32'h0000_0080;
    @(negedge clk);
    chk("t4_src_before", 32'(src1), 1);
    nxt(); treq = 1'b0;
    @(negedge clk);
    chk("t4_src_after", 32'(src1), 3);
    nxt(); stall = 1'b0;
    q1.push_back(mk(32'h0000_0080, 2'd3, 1'b0));
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("t4_flush_ign", 32'(ign1), 1);
    nxt();
    @(negedge clk);
    chk("t4_idle", 32'(busy1), 0);

    // Reset mid-PEND drops the redirect
    nxt();
    breq = 1'b1; bt = 32'h0000_0600; stall = 1'b1;
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("t6_pend_busy", 32'(busy1), 1);
    nxt(); clr();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy1), 0);
    chk("t6_rst_strobe", 32'(s1), 0);
    chk("t6_rst_src", 32'(src1), 0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_after_busy", 32'(busy1), 0);
      chk("t6_after_strobe", 32'(s1), 0);
      nxt();
    end

    // FLUSH_CYCLES=3 with a 2-cycle stall mid-flush
    en1 = 1'b0; en3 = 1'b1;
    jreq = 1'b1; jt = 32'h0000_1000;
    q3.push_back(mk(32'h0000_1000, 2'd2, 1'b0));
    @(negedge clk);
    chk("t5_pre_ign", 32'(ign3), 0);
    nxt(); clr();
    @(negedge clk);
    chk("t5_ign_c1", 32'(ign3), 1);
    nxt(); stall = 1'b1;
    @(negedge clk);
    chk("t5_ign_c2", 32'(ign3), 1);
    nxt(); jreq = 1'b1; jt = 32'h0000_2000;
    @(negedge clk);
    chk("t5_ign_c3", 32'(ign3), 1);
    nxt(); stall = 1'b0;
    @(negedge clk);
    chk("t5_ign_c4", 32'(ign3), 1);
    nxt(); clr();
    @(negedge clk);
    chk("t5_ign_c5", 32'(ign3), 1);
    nxt();
    @(negedge clk);
    chk("t5_end_ign", 32'(ign3), 0);
    chk("t5_end_busy", 32'(busy3), 0);

    // Trap preempting FLUSH: immediate strobe and counter reload
    nxt();
    jreq = 1'b1; jt = 32'h0000_3000;
    q3.push_back(mk(32'h0000_3000, 2'd2, 1'b0));
    @(negedge clk);
    nxt(); clr();
    @(negedge clk);
    nxt();
    treq = 1'b1; tt = 32'h0000_0123;
    q3.push_back(mk(32'h0000_0122, 2'd3, 1'b1));
    @(negedge clk);
    chk("t7_ign_trap", 32'(ign3), 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); clr();
      @(negedge clk);
      chk("t7_ign_reload", 32'(ign3), 1);
    end
    nxt();
    @(negedge clk);
    chk("t7_end_busy", 32'(busy3), 0);

    nxt();
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Central PC-redirect scheduler for the RV32 core.
- Arbitrates redirect requests from the trap unit, jump unit and branch unit, and drives the single PC-update port into fetch.
- Holds a redirect that cannot be consumed while fetch is stalled.
- Squashes the wrong-path instructions that follow an accepted redirect for a programmable number of advancing cycles.

Parameters:
- XLEN, 32: PC/target width.
- FLUSH_CYCLES, 1: advancing cycles squashed after each accepted redirect. Legal range 1..7.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst  in  1  asynchronous active-low reset.
- i_stall  in  1  fetch stalled; a redirect cannot be consumed and flush count does not advance.
- i_trap_req  in  1  trap/exception redirect request.
- i_trap_target  in  XLEN  trap vector.
- i_jump_req  in  1  JAL/JALR redirect request.
- i_jump_target  in  XLEN  jump target.
- i_branch_req  in  1  taken-branch redirect request.
- i_branch_target  in  XLEN  branch target.
- o_pc_update_control  out  1  PC load strobe to fetch.
- o_pc_update_val  out  XLEN  new PC.
- o_ignore_curr_inst  out  1  squash the instruction currently in decode/execute.
- o_redirect_src  out  2  source of the current or pending redirect: 0 none, 1 branch, 2 jump, 3 trap.
- o_misaligned  out  1  accepted target has bit[1] set (instruction-address-misaligned).
- o_busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst.
- Reset values: state IDLE, counter 0, latched target 0, latched src 0. All outputs 0 while i_rst is low. Reset asserted mid-PEND or mid-FLUSH drops the redirect; nothing is replayed.
- Arbitration: fixed priority, trap > jump > branch.
  - winner_target = selected target with bit[0] forced to 0 (JALR rule).
  - Losers are dropped, not queued.
- States: IDLE, PEND, FLUSH.
- IDLE:
  - Any request with i_stall=0: o_pc_update_control=1 combinationally in the same cycle. o_pc_update_val=winner_target. Next state FLUSH, counter loaded with FLUSH_CYCLES.
  - Any request with i_stall=1: latch winner target and src. No strobe. Next state PEND.
  - No request: all strobes 0. o_pc_update_val=0. o_redirect_src=0.
- PEND:
  - o_redirect_src = latched src.
  - A new i_trap_req replaces a latched branch/jump (target and src overwritten). Jump/branch requests are ignored in PEND.
  - While i_stall=1: hold, no strobe.
  - When i_stall=0: o_pc_update_control=1 with the latched target (or the trap target if a trap arrives that same cycle). Next state FLUSH, counter=FLUSH_CYCLES.
- FLUSH:
  - o_ignore_curr_inst=1 every cycle.
  - Counter decrements only on cycles with i_stall=0. On a non-stalled cycle with counter==1, next state is IDLE.
  - Jump/branch requests are ignored; they come from squashed instructions.
  - i_trap_req with i_stall=0: immediate redirect strobe, counter reloaded to FLUSH_CYCLES, stay in FLUSH.
  - i_trap_req with i_stall=1: latch, next state PEND.
- o_misaligned: asserted in the same cycle as o_pc_update_control when the output target has bit[1]=1. Zero otherwise.
- o_pc_update_val is 0 whenever o_pc_update_control=0.
- o_redirect_src is valid while o_pc_update_control=1 or in PEND.
- Strobe rate: exactly one o_pc_update_control pulse per accepted redirect. Never two in consecutive cycles, except when a trap preempts a FLUSH.
- Width: all target arithmetic is XLEN wide. No wrap handling is needed; targets are passed through unchanged apart from bit[0].

Test Plan:
- Jump in IDLE, no stall: i_jump_req=1, target 0x0000_1003, FLUSH_CYCLES=1 -> same cycle strobe=1, val=0x0000_1002, misaligned=1, src=2; next cycle ignore=1, busy=1; cycle after that IDLE.
- Simultaneous requests: trap 0x0000_0100, jump 0x200 and branch 0x300 in one cycle -> val=0x100, src=3; jump and branch never redirect.
- Stall deferral: branch 0x400 with i_stall=1 for 3 cycles -> PEND, no strobe, src=1; when stall drops, strobe with val=0x400, then FLUSH.
- Trap overrides pending: branch latched in PEND, then trap 0x80 while still stalled -> on release, single strobe with val=0x80, src=3.
- Flush with stall, FLUSH_CYCLES=3: stall 2 cycles mid-flush -> ignore held high for 3 non-stalled cycles plus 2 stalled cycles (5 total); a jump request during FLUSH produces no strobe.
- Reset mid-PEND: drive i_rst low while in PEND -> all outputs 0 immediately; after release, no strobe without a new request.
